// File: rtl/counter3_updown.sv
// 3-bit up/down counter with synchronous parallel load, count enable,
// a registered wrap pulse and a combinational terminal-count flag.
module counter3_updown #(
  parameter int unsigned          WIDTH     = 3,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Priority: load, then enabled count, then hold; wrap flags the step that rolled over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= RESET_VAL;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d_in;
      wrap <= 1'b0;
    end else if (en) begin
      if (up) begin
        q    <= q + ONE;
        wrap <= (q == '1);
      end else begin
        q    <= q - ONE;
        wrap <= (q == '0);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign tc = up ? (q == '1) : (q == '0);

endmodule
